expr_sweep_ctrl: RTL and testbench

- Sequential stimulus/capture stage for a 4-input, 3-output combinational expression block under test (DUT).
- Upstream side: sweeps all 16 input vectors onto the DUT inputs a/b/c/d.
- Downstream side: samples the DUT results and checks res1/res2 against an internal golden model.
- Accumulates all three results into a 16-bit MISR signature, so the compiler-generated netlist can be checked in simulation and on silicon with one compare.

---
 rtl/expr_sweep_ctrl.sv | 116 +++++++++++
 tb/tb_expr_sweep_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/expr_sweep_ctrl.sv
// Sweeps all 16 input vectors into a 4-in/3-out expression block,
// checks res1/res2 against a golden model and folds all results into a MISR.
module expr_sweep_ctrl #(
   parameter int          SETTLE_CYCLES = 2,
   parameter logic [15:0] MISR_POLY     = 16'h1021,
   parameter logic [15:0] MISR_SEED     = 16'hFFFF
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   output logic        a,
   output logic        b,
   output logic        c,
   output logic        d,
   input  logic        res1,
   input  logic        res2,
   input  logic        res3,
   output logic        busy,
   output logic        done,
   output logic [15:0] signature,
   output logic [7:0]  err_count,
   output logic        first_err_valid,
   output logic [3:0]  first_err_vec
);

   typedef enum logic [1:0] {
      IDLE,
      DRIVE,
      SAMPLE,
      DONE
   } state_t;

   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);

   state_t      state;
   logic [3:0]  vec;
   logic [3:0]  settle_cnt;
   logic        exp1;
   logic        exp2;
   logic        mismatch;
   logic [15:0] misr_next;

   assign a = vec[3];
   assign b = vec[2];
   assign c = vec[1];
   assign d = vec[0];

   always_comb begin
      exp1      = ~(vec[3] & vec[2]);
      exp2      = (vec[3] & vec[2]) | ~(vec[1] ^ vec[0]);
      mismatch  = (res1 != exp1) | (res2 != exp2);
      misr_next = {signature[14:0], 1'b0}
                ^ (signature[15] ? MISR_POLY : 16'h0000)
                ^ {13'b0, res1, res2, res3};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state           <= IDLE;
         vec             <= 4'h0;
         settle_cnt      <= 4'h0;
         busy            <= 1'b0;
         done            <= 1'b0;
         signature       <= MISR_SEED;
         err_count       <= 8'h00;
         first_err_valid <= 1'b0;
         first_err_vec   <= 4'h0;
      end else begin
         unique case (state)
            IDLE, DONE: begin
               if (start) begin
                  state           <= DRIVE;
                  vec             <= 4'h0;
                  settle_cnt      <= 4'h0;
                  busy            <= 1'b1;
                  done            <= 1'b0;
                  signature       <= MISR_SEED;
                  err_count       <= 8'h00;
                  first_err_valid <= 1'b0;
                  first_err_vec   <= 4'h0;
               end
            end
            DRIVE: begin
               settle_cnt <= settle_cnt + 4'h1;
               if (settle_cnt == SETTLE_LAST) begin
                  state <= SAMPLE;
               end
            end
            SAMPLE: begin
               signature <= misr_next;
               // one count per vector even if both results are wrong
               if (mismatch) begin
                  if (err_count != 8'hFF) begin
                     err_count <= err_count + 8'h01;
                  end
                  if (!first_err_valid) begin
                     first_err_valid <= 1'b1;
                     first_err_vec   <= vec;
                  end
               end
               if (vec == 4'hF) begin
                  state <= DONE;
                  busy  <= 1'b0;
                  done  <= 1'b1;
               end else begin
                  vec        <= vec + 4'h1;
                  settle_cnt <= 4'h0;
                  state      <= DRIVE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_expr_sweep_ctrl.sv
// Directed + randomized bench for expr_sweep_ctrl with an
// expression-block model and a whole-run reference model.
module tb_expr_sweep_ctrl;

   logic        clk;
   logic        rst_n;
   logic        start;
   logic        start1;
   logic        a, b, c, d;
   logic        a1, b1, c1, d1;
   logic        res1, res2, res3;
   logic        r1_1, r1_2, r1_3;
   logic        busy, done, busy1, done1;
   logic [15:0] signature, signature1;
   logic [7:0]  err_count, err_count1;
   logic        first_err_valid, first_err_valid1;
   logic [3:0]  first_err_vec, first_err_vec1;

   int n_assert = 0;
   int n_fail   = 0;

   // fault controls for the modelled expression block
   logic        s1_en = 0, s1_val = 0;
   logic        s2_en = 0, s2_val = 0;
   logic [15:0] f1 = 0, f2 = 0, f3 = 0;

   expr_sweep_ctrl #(.SETTLE_CYCLES(2)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .a(a), .b(b), .c(c), .d(d),
      .res1(res1), .res2(res2), .res3(res3),
      .busy(busy), .done(done), .signature(signature),
      .err_count(err_count), .first_err_valid(first_err_valid),
      .first_err_vec(first_err_vec)
   );

   expr_sweep_ctrl #(.SETTLE_CYCLES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1),
      .a(a1), .b(b1), .c(c1), .d(d1),
      .res1(r1_1), .res2(r1_2), .res3(r1_3),
      .busy(busy1), .done(done1), .signature(signature1),
      .err_count(err_count1), .first_err_valid(first_err_valid1),
      .first_err_vec(first_err_vec1)
   );

   initial clk = 0;
   always #5 clk = ~clk;

   function automatic logic gold1(input logic [3:0] v);
      return !(v[3] && v[2]);
   endfunction

   function automatic logic gold2(input logic [3:0] v);
      return (v[3] && v[2]) || (v[1] == v[0]);
   endfunction

   function automatic logic [2:0] blk(input logic [3:0] v);
      logic x1, x2, x3;
      x1 = s1_en ? s1_val : gold1(v) ^ f1[v];
      x2 = s2_en ? s2_val : gold2(v) ^ f2[v];
      x3 = (^v) ^ f3[v];
      return {x1, x2, x3};
   endfunction

   always_comb begin
      {res1, res2, res3} = blk({a, b, c, d});
      {r1_1, r1_2, r1_3} = blk({a1, b1, c1, d1});
   end

   task automatic ref_run(output logic [15:0] sig, output int errs,
                          output logic fv, output logic [3:0] fvec);
      logic [2:0] r;
      sig  = 16'hFFFF;
      errs = 0;
      fv   = 0;
      fvec = 0;
      for (int v = 0; v < 16; v++) begin
         r = blk(4'(v));
         if (r[2] != gold1(4'(v)) || r[1] != gold2(4'(v))) begin
            if (errs < 255) errs++;
            if (!fv) begin
               fv   = 1;
               fvec = 4'(v);
            end
         end
         sig = {sig[14:0], 1'b0} ^ (sig[15] ? 16'h1021 : 16'h0) ^ {13'b0, r};
      end
   endtask

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (done !== 1'b1 && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run2(input string tag, output logic [15:0] sig_out);
      logic [15:0] es;
      int          ee, n;
      logic        efv;
      logic [3:0]  efvec;
      ref_run(es, ee, efv, efvec);
      @(negedge clk) start = 1;
      @(posedge clk); #1;
      start = 0;
      chk({tag, "_acc"}, {busy, done, err_count, first_err_valid, a, b, c, d},
          {1'b1, 1'b0, 8'h00, 1'b0, 4'h0});
      chk({tag, "_seed"}, signature, 16'hFFFF);
      wait_done(n);
      chk({tag, "_lat"}, n, 48);
      chk({tag, "_end"}, {busy, a, b, c, d}, {1'b0, 4'hF});
      chk({tag, "_sig"}, signature, es);
      chk({tag, "_err"}, err_count, ee);
      chk({tag, "_fv"}, {first_err_valid, first_err_vec}, {efv, efvec});
      sig_out = signature;
   endtask

   initial begin
      logic [15:0] gsig, tsig, es;
      int          ee, n;
      logic        efv;
      logic [3:0]  efvec;

      rst_n  = 0;
      start  = 0;
      start1 = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out", {a, b, c, d, busy, done, err_count, first_err_valid,
                      first_err_vec}, 0);
      chk("rst_sig", signature, 16'hFFFF);
      @(negedge clk) rst_n = 1;

      run2("gold", gsig);

      s1_en = 1; s1_val = 0;
      run2("r1s0", tsig);
      chk("r1s0_n", {err_count, first_err_valid, first_err_vec},
          {8'd12, 1'b1, 4'h0});

      s1_en = 0; s2_en = 1; s2_val = 1;
      run2("r2s1", tsig);
      chk("r2s1_n", {err_count, first_err_vec}, {8'd6, 4'h1});

      s1_en = 1; s1_val = 0; s2_val = 0;
      for (int i = 0; i < 17; i++) begin
         run2("both0", tsig);
         chk("both0_n", err_count, 16);
      end
      s1_en = 0; s2_en = 0;

      for (int i = 0; i < 6; i++) begin
         f1 = 16'($urandom);
         f2 = 16'($urandom);
         f3 = 16'($urandom);
         repeat ($urandom_range(0, 5)) @(posedge clk);
         run2("rand", tsig);
      end
      f1 = 0; f2 = 0; f3 = 0;

      // abort during vector 7
      @(negedge clk) start = 1;
      @(posedge clk); #1;
      start = 0;
      n = 0;
      while ({a, b, c, d} !== 4'h7 && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      chk("abort_reach", {a, b, c, d}, 4'h7);
      @(negedge clk) rst_n = 0;
      @(posedge clk); #1;
      chk("abort_out", {a, b, c, d, busy, done, err_count, first_err_valid,
                        first_err_vec}, 0);
      chk("abort_sig", signature, 16'hFFFF);
      @(negedge clk) rst_n = 1;
      run2("reacc", tsig);
      chk("reacc_same", tsig, gsig);

      // start held high: no restart mid-run, restart from DONE
      @(negedge clk) start = 1;
      @(posedge clk); #1;
      wait_done(n);
      chk("hold_lat", n, 48);
      chk("hold_sig", signature, gsig);
      @(posedge clk); #1;
      chk("hold_restart", {busy, done, a, b, c, d}, {1'b1, 1'b0, 4'h0});
      chk("hold_reseed", signature, 16'hFFFF);
      start = 0;
      wait_done(n);
      chk("hold_lat2", n, 48);
      chk("hold_sig2", signature, gsig);

      // SETTLE_CYCLES=1 instance
      ref_run(es, ee, efv, efvec);
      @(negedge clk) start1 = 1;
      @(posedge clk); #1;
      start1 = 0;
      for (int j = 0; j < 32; j++) begin
         chk("s1_hold", {busy1, done1, a1, b1, c1, d1},
             {1'b1, 1'b0, 4'(j / 2)});
         @(posedge clk); #1;
      end
      chk("s1_done", {busy1, done1, a1, b1, c1, d1}, {1'b0, 1'b1, 4'hF});
      chk("s1_sig", signature1, es);
      chk("s1_err", {err_count1, first_err_valid1}, {8'(ee), efv});

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_assert, n_fail);
      $finish;
   end

endmodule
